// File: rtl/retire_trace_checker.sv
// Retire-trace checker: buffers golden trace records and compares each core retire
// event against the FIFO head, flagging PASS on a matched halt or the first failure cause.
module retire_trace_checker #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_INST   = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exp_valid_p1,
    output logic        exp_ready_p1,
    input  logic [69:0] exp_rec_p1,
    input  logic        ret_valid_p1,
    input  logic [69:0] ret_rec_p1,
    output logic [31:0] inst_count_p1,
    output logic        done_p1,
    output logic        err_p1,
    output logic [2:0]  err_code_p1,
    output logic [15:0] err_pc_p1
);

    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] MAX_CNT  = 32'(MAX_INST);

    localparam logic [2:0] E_PC    = 3'd1;
    localparam logic [2:0] E_FLAG  = 3'd2;
    localparam logic [2:0] E_REG   = 3'd3;
    localparam logic [2:0] E_MEM   = 3'd4;
    localparam logic [2:0] E_UFLOW = 3'd5;
    localparam logic [2:0] E_TMO   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_en;
    logic [69:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_cnt;
    logic [31:0]     r_inst;
    logic            r_done;
    logic            r_err;
    logic [2:0]      r_code;
    logic [15:0]     r_pc;

    logic            w_full;
    logic            w_empty;
    logic            w_terminal;
    logic            w_push;
    logic            w_ret;
    logic            w_ret_run;
    logic            w_pop;
    logic [69:0]     w_head;
    logic            w_pc_mis;
    logic            w_flag_mis;
    logic            w_reg_mis;
    logic            w_mem_mis;
    logic [31:0]     w_inst_nxt;
    logic            w_fail;
    logic [2:0]      w_code;

    // Release of rst_n only takes effect one clock later: nothing updates on the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_en <= 1'b0;
        else        r_en <= 1'b1;
    end

    assign w_full       = (r_cnt == FULL_CNT);
    assign w_empty      = (r_cnt == '0);
    assign w_terminal   = (r_state == S_PASS) || (r_state == S_FAIL);
    assign exp_ready_p1 = r_en && !w_full && !w_terminal;
    assign w_push       = exp_valid_p1 && exp_ready_p1;
    assign w_ret        = r_en && ret_valid_p1;
    assign w_ret_run    = w_ret && (r_state == S_RUN);
    assign w_pop        = w_ret_run && !w_empty;
    assign w_head       = r_mem[r_rd_ptr];

    // Reg and mem payloads only matter when the golden record says they were written.
    assign w_pc_mis   = (w_head[66:51] != ret_rec_p1[66:51]);
    assign w_flag_mis = (w_head[69:67] != ret_rec_p1[69:67]);
    assign w_reg_mis  = w_head[67] && (w_head[50:32] != ret_rec_p1[50:32]);
    assign w_mem_mis  = w_head[68] && (w_head[31:0] != ret_rec_p1[31:0]);
    assign w_inst_nxt = (r_inst == '1) ? r_inst : r_inst + 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_code      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ret) begin
                    w_fail = 1'b1;
                    w_code = E_UFLOW;
                end else if (w_push) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ret) begin
                    w_fail = 1'b1;
                    if (w_empty)         w_code = E_UFLOW;
                    else if (w_pc_mis)   w_code = E_PC;
                    else if (w_flag_mis) w_code = E_FLAG;
                    else if (w_reg_mis)  w_code = E_REG;
                    else if (w_mem_mis)  w_code = E_MEM;
                    else begin
                        w_fail = 1'b0;
                        if (w_head[69]) begin
                            w_state_nxt = S_PASS;
                        end else if (w_inst_nxt == MAX_CNT) begin
                            w_fail = 1'b1;
                            w_code = E_TMO;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (w_fail) w_state_nxt = S_FAIL;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= exp_rec_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_inst   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= '0;
            r_pc     <= '0;
        end else if (r_en) begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_ret_run) r_inst <= w_inst_nxt;
            if (w_state_nxt == S_PASS && r_state == S_RUN) r_done <= 1'b1;
            if (w_fail) begin
                r_err  <= 1'b1;
                r_code <= w_code;
                r_pc   <= ret_rec_p1[66:51];
            end
        end
    end

    assign inst_count_p1 = r_inst;
    assign done_p1       = r_done;
    assign err_p1        = r_err;
    assign err_code_p1   = r_code;
    assign err_pc_p1     = r_pc;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Directed bench for retire_trace_checker: table of per-cycle vectors plus
// hand-written sequences for FIFO full/simultaneous push-pop, timeout and mid-run reset.
module tb_retire_trace_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exp_valid_p1 = 1'b0;
    logic        exp_ready_p1;
    logic [69:0] exp_rec_p1 = '0;
    logic        ret_valid_p1 = 1'b0;
    logic [69:0] ret_rec_p1 = '0;
    logic [31:0] inst_count_p1;
    logic        done_p1;
    logic        err_p1;
    logic [2:0]  err_code_p1;
    logic [15:0] err_pc_p1;

    int total = 0;
    int bad   = 0;

    retire_trace_checker #(
        .FIFO_DEPTH(4),
        .MAX_INST  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_valid_p1 (exp_valid_p1),
        .exp_ready_p1 (exp_ready_p1),
        .exp_rec_p1   (exp_rec_p1),
        .ret_valid_p1 (ret_valid_p1),
        .ret_rec_p1   (ret_rec_p1),
        .inst_count_p1(inst_count_p1),
        .done_p1      (done_p1),
        .err_p1       (err_p1),
        .err_code_p1  (err_code_p1),
        .err_pc_p1    (err_pc_p1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired act=running req=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;
        bit          ev;
        logic [69:0] er;
        bit          rv;
        logic [69:0] rr;
        bit          xr;
        int unsigned xc;
        bit          xd;
        bit          xe;
        logic [2:0]  xcode;
        logic [15:0] xpc;
    } vec_t;

    vec_t tv[$];

    function automatic logic [69:0] mk(bit h, bit mw, bit rw, logic [15:0] pc, logic [2:0] ri,
                                       logic [15:0] rd, logic [15:0] ma, logic [15:0] md);
        return {h, mw, rw, pc, ri, rd, ma, md};
    endfunction

    function automatic vec_t v(bit ev, logic [69:0] er, bit rv, logic [69:0] rr, bit xr,
                               int unsigned xc, bit xd, bit xe, logic [2:0] xcode,
                               logic [15:0] xpc);
        vec_t t;
        t.rst = 1'b0; t.ev = ev; t.er = er; t.rv = rv; t.rr = rr; t.xr = xr;
        t.xc = xc; t.xd = xd; t.xe = xe; t.xcode = xcode; t.xpc = xpc;
        return t;
    endfunction

    function automatic vec_t rstv();
        vec_t t;
        t = v(0, '0, 0, '0, 0, 0, 0, 0, 3'd0, 16'd0);
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Pre-edge: exp_ready; post-edge: registered status outputs.
    task automatic step(input string tag, input bit ev, input logic [69:0] er, input bit rv,
                        input logic [69:0] rr, input bit xr, input int unsigned xc,
                        input bit xd, input bit xe, input logic [2:0] xcode,
                        input logic [15:0] xpc);
        @(negedge clk);
        exp_valid_p1 = ev;
        exp_rec_p1   = er;
        ret_valid_p1 = rv;
        ret_rec_p1   = rr;
        #1;
        chk({tag, "_ready"}, 32'(exp_ready_p1), 32'(xr));
        @(posedge clk);
        #1;
        chk({tag, "_cnt"},  inst_count_p1,     xc);
        chk({tag, "_done"}, 32'(done_p1),      32'(xd));
        chk({tag, "_err"},  32'(err_p1),       32'(xe));
        chk({tag, "_code"}, 32'(err_code_p1),  32'(xcode));
        chk({tag, "_pc"},   32'(err_pc_p1),    32'(xpc));
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n        = 1'b0;
        exp_valid_p1 = 1'b0;
        ret_valid_p1 = 1'b0;
        exp_rec_p1   = '0;
        ret_rec_p1   = '0;
        #1;
        chk({tag, "_rst_ready"}, 32'(exp_ready_p1), 32'd0);
        chk({tag, "_rst_cnt"},   inst_count_p1,     32'd0);
        chk({tag, "_rst_done"},  32'(done_p1),      32'd0);
        chk({tag, "_rst_err"},   32'(err_p1),       32'd0);
        chk({tag, "_rst_code"},  32'(err_code_p1),  32'd0);
        chk({tag, "_rst_pc"},    32'(err_pc_p1),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rel_ready"}, 32'(exp_ready_p1), 32'd1);
        chk({tag, "_rel_cnt"},   inst_count_p1,     32'd0);
        chk({tag, "_rel_err"},   32'(err_p1),       32'd0);
    endtask

    initial begin
        logic [69:0] z, a, b, h, m, mr, e, r, x, d, dr, f, fr, g, gr, q;
        logic [69:0] p [6];
        z  = '0;
        a  = mk(0, 0, 1, 16'h0000, 3'd1, 16'h0005, 16'h0000, 16'h0000);
        b  = mk(0, 1, 0, 16'h0002, 3'd0, 16'h0000, 16'h0010, 16'h0005);
        h  = mk(1, 0, 0, 16'h0004, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        m  = mk(0, 0, 0, 16'h0004, 3'd3, 16'h1234, 16'h0055, 16'h0066);
        mr = mk(0, 0, 0, 16'h0004, 3'd5, 16'h9999, 16'h00AA, 16'h00BB);
        e  = mk(0, 0, 1, 16'h0006, 3'd2, 16'h00FF, 16'h0000, 16'h0000);
        r  = mk(0, 0, 1, 16'h0006, 3'd2, 16'h00FE, 16'h0000, 16'h0000);
        x  = mk(0, 0, 0, 16'h0100, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        d  = mk(0, 0, 0, 16'h0010, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        dr = mk(1, 0, 0, 16'h0012, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        f  = mk(0, 0, 0, 16'h0020, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        fr = mk(0, 1, 0, 16'h0020, 3'd0, 16'h0000, 16'h0030, 16'h0001);
        g  = mk(0, 1, 0, 16'h000A, 3'd0, 16'h0000, 16'h0020, 16'h0001);
        gr = mk(0, 1, 0, 16'h000A, 3'd7, 16'hBEEF, 16'h0020, 16'h0002);
        q  = mk(0, 0, 1, 16'h0300, 3'd4, 16'h0042, 16'h0000, 16'h0000);
        for (int i = 0; i < 6; i++)
            p[i] = mk(0, 0, 1, 16'h0040 + 16'(2 * i), 3'd2, 16'h0100 + 16'(i), 16'h0, 16'h0);

        // Three-record program ending in halt, then PASS is frozen.
        tv.push_back(rstv());
        tv.push_back(v(1, a, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(1, b, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(1, h, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, a, 1, 1, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, b, 1, 2, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, h, 1, 3, 1, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 0, z, 0, 3, 1, 0, 3'd0, 16'h0));
        tv.push_back(v(1, a, 1, a, 0, 3, 1, 0, 3'd0, 16'h0));
        // Masked compare passes, then reg data mismatch; error held afterwards.
        tv.push_back(rstv());
        tv.push_back(v(1, m, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(1, e, 1, mr, 1, 1, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, r, 1, 2, 0, 1, 3'd3, 16'h0006));
        tv.push_back(v(0, z, 0, z, 0, 2, 0, 1, 3'd3, 16'h0006));
        tv.push_back(v(1, e, 1, e, 0, 2, 0, 1, 3'd3, 16'h0006));
        // Retire in IDLE is an underflow and does not count.
        tv.push_back(rstv());
        tv.push_back(v(0, z, 1, x, 1, 0, 0, 1, 3'd5, 16'h0100));
        tv.push_back(v(0, z, 0, z, 0, 0, 0, 1, 3'd5, 16'h0100));
        // PC and halt flag both wrong: PC code wins.
        tv.push_back(rstv());
        tv.push_back(v(1, d, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, dr, 1, 1, 0, 1, 3'd1, 16'h0012));
        // Flag mismatch only.
        tv.push_back(rstv());
        tv.push_back(v(1, f, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, fr, 1, 1, 0, 1, 3'd2, 16'h0020));
        // Mem data mismatch with unwritten reg fields differing.
        tv.push_back(rstv());
        tv.push_back(v(1, g, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, gr, 1, 1, 0, 1, 3'd4, 16'h000A));
        // Underflow in RUN after the FIFO drains still counts the retire.
        tv.push_back(rstv());
        tv.push_back(v(1, a, 0, z, 1, 0, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, a, 1, 1, 0, 0, 3'd0, 16'h0));
        tv.push_back(v(0, z, 1, b, 1, 2, 0, 1, 3'd5, 16'h0002));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst)
                do_reset($sformatf("v%0d", i));
            else
                step($sformatf("v%0d", i), tv[i].ev, tv[i].er, tv[i].rv, tv[i].rr, tv[i].xr,
                     tv[i].xc, tv[i].xd, tv[i].xe, tv[i].xcode, tv[i].xpc);
        end

        // FIFO full, blocked push, then simultaneous push/pop and in-order drain.
        do_reset("full");
        for (int i = 0; i < 4; i++)
            step($sformatf("fill%0d", i), 1, p[i], 0, z, 1, 0, 0, 0, 3'd0, 16'h0);
        step("full_blk",  1, p[4], 1, p[0], 0, 1, 0, 0, 3'd0, 16'h0);
        step("full_pp",   1, p[4], 1, p[1], 1, 2, 0, 0, 3'd0, 16'h0);
        step("full_p5",   1, p[5], 0, z,    1, 2, 0, 0, 3'd0, 16'h0);
        step("full_r2",   0, z,    1, p[2], 0, 3, 0, 0, 3'd0, 16'h0);
        step("full_r3",   0, z,    1, p[3], 1, 4, 0, 0, 3'd0, 16'h0);
        step("full_r4",   0, z,    1, p[4], 1, 5, 0, 0, 3'd0, 16'h0);
        step("full_r5",   0, z,    1, p[5], 1, 6, 0, 0, 3'd0, 16'h0);

        // Timeout after the eighth matching non-halt retire.
        do_reset("tmo");
        for (int i = 0; i < 8; i++) begin
            logic [69:0] t;
            t = mk(0, 0, 1, 16'(2 * i), 3'd1, 16'(i), 16'h0, 16'h0);
            step($sformatf("tmo_push%0d", i), 1, t, 0, z, 1, i, 0, 0, 3'd0, 16'h0);
            step($sformatf("tmo_ret%0d", i), 0, z, 1, t, 1, i + 1, 0, (i == 7),
                 (i == 7) ? 3'd6 : 3'd0, (i == 7) ? 16'h000E : 16'h0);
        end
        step("tmo_hold", 0, z, 0, z, 0, 8, 0, 1, 3'd6, 16'h000E);

        // Reset mid-run discards the buffered record b.
        do_reset("mid");
        step("mid_pa", 1, a, 0, z, 1, 0, 0, 0, 3'd0, 16'h0);
        step("mid_pb", 1, b, 0, z, 1, 0, 0, 0, 3'd0, 16'h0);
        step("mid_ra", 0, z, 1, a, 1, 1, 0, 0, 3'd0, 16'h0);
        do_reset("mid2");
        step("mid_pq", 1, q, 0, z, 1, 0, 0, 0, 3'd0, 16'h0);
        step("mid_rq", 0, z, 1, q, 1, 1, 0, 0, 3'd0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
